// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - strobe generator, event qualification, receive FIFO and error status
// for the oversampling UART receive core.
module uart_rx_ctrl #(
  parameter int Oversample = 16,
  parameter int DivWidth   = 16,
  parameter int FifoDepth  = 4
) (
  input  logic                         clk,
  input  logic                         nReset,
  input  logic                         enable,
  input  logic [DivWidth-1:0]          divisor,
  output logic                         rxEn,
  input  logic                         rxDone,
  input  logic                         rxErr,
  input  logic [7:0]                   rxData,
  output logic [7:0]                   data,
  output logic                         valid,
  input  logic                         ready,
  output logic [$clog2(FifoDepth):0]   fifoCount,
  output logic                         overrun,
  output logic                         frameErr,
  output logic [7:0]                   errCount,
  input  logic                         clearErr
);

  localparam int PW = $clog2(FifoDepth);
  localparam int CW = PW + 1;

  logic [DivWidth-1:0] r_divCnt;
  logic                r_capPend;
  logic [7:0]          r_mem [FifoDepth];
  logic [PW-1:0]       r_wrPtr;
  logic [PW-1:0]       r_rdPtr;
  logic [CW-1:0]       r_count;
  logic                r_valid;
  logic [7:0]          r_data;
  logic                r_overrun;
  logic                r_frameErr;
  logic [7:0]          r_errCount;

  logic                w_rxEn;
  logic                w_byteEv;
  logic                w_errEv;
  logic                w_full;
  logic                w_pop;
  logic                w_push;
  logic                w_drop;
  logic [PW-1:0]       w_rdNext;
  logic [CW-1:0]       w_countNext;

  // Strobe is combinational so an enable rising straight out of reset strobes in the same cycle.
  assign w_rxEn   = enable && (r_divCnt == '0);
  assign w_byteEv = rxDone && w_rxEn;
  assign w_errEv  = rxErr && w_rxEn;

  assign w_full   = (r_count == CW'(FifoDepth));
  assign w_pop    = r_valid && ready;
  assign w_push   = r_capPend && (!w_full || w_pop);
  assign w_drop   = r_capPend && w_full && !w_pop;
  assign w_rdNext = r_rdPtr + PW'(1);

  always_comb begin
    w_countNext = r_count;
    if (w_push && !w_pop)
      w_countNext = r_count + CW'(1);
    else if (w_pop && !w_push)
      w_countNext = r_count - CW'(1);
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_divCnt <= '0;
    end else if (!enable || r_divCnt == '0) begin
      r_divCnt <= divisor;
    end else begin
      r_divCnt <= r_divCnt - DivWidth'(1);
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) r_capPend <= 1'b0;
    else         r_capPend <= w_byteEv;
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wrPtr] <= rxData;
  end

  // data is a registered copy of the head; it is refreshed only when the head changes.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
      r_data  <= 8'h00;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + PW'(1);
      if (w_pop)  r_rdPtr <= w_rdNext;
      r_count <= w_countNext;
      r_valid <= (w_countNext != '0);
      if (w_push && (r_count == '0 || (w_pop && r_count == CW'(1))))
        r_data <= rxData;
      else if (w_pop && r_count != CW'(1))
        r_data <= r_mem[w_rdNext];
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_overrun  <= 1'b0;
      r_frameErr <= 1'b0;
      r_errCount <= 8'h00;
    end else if (clearErr) begin
      r_overrun  <= w_drop;
      r_frameErr <= w_errEv;
      r_errCount <= {7'b0, w_errEv};
    end else begin
      if (w_drop)  r_overrun  <= 1'b1;
      if (w_errEv) r_frameErr <= 1'b1;
      if (w_errEv && r_errCount != 8'hFF) r_errCount <= r_errCount + 8'h01;
    end
  end

  always @(posedge clk) begin
    if (nReset) begin
      assert (Oversample >= 2 && FifoDepth >= 2 && (FifoDepth & (FifoDepth - 1)) == 0);
      assert (r_count <= CW'(FifoDepth));
    end
  end

  assign rxEn      = w_rxEn;
  assign data      = r_data;
  assign valid     = r_valid;
  assign fifoCount = r_count;
  assign overrun   = r_overrun;
  assign frameErr  = r_frameErr;
  assign errCount  = r_errCount;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - directed self-checking bench for uart_rx_ctrl.
module tb_uart_rx_ctrl;

  logic        clk = 1'b0;
  logic        nReset;
  logic        enable;
  logic [15:0] divisor;
  logic        rxEn;
  logic        rxDone;
  logic        rxErr;
  logic [7:0]  rxData;
  logic [7:0]  data;
  logic        valid;
  logic        ready;
  logic [2:0]  fifoCount;
  logic        overrun;
  logic        frameErr;
  logic [7:0]  errCount;
  logic        clearErr;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  uart_rx_ctrl #(.Oversample(16), .DivWidth(16), .FifoDepth(4)) dut (
    .clk(clk), .nReset(nReset), .enable(enable), .divisor(divisor), .rxEn(rxEn),
    .rxDone(rxDone), .rxErr(rxErr), .rxData(rxData), .data(data), .valid(valid),
    .ready(ready), .fifoCount(fifoCount), .overrun(overrun), .frameErr(frameErr),
    .errCount(errCount), .clearErr(clearErr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next();
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    enable = 1'b1;
    rxDone = 1'b1;
    rxData = b;
    #1 check("send_rxEn", 32'(rxEn), 32'd1);
    next();
    enable = 1'b0;
    rxDone = 1'b0;
    next();
  endtask

  initial begin
    #200000;
    n_errors++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    logic [7:0] exp_d [4];
    exp_d = '{8'h02, 8'h03, 8'h04, 8'h06};

    nReset = 1'b0; enable = 1'b0; divisor = 16'd3; rxDone = 1'b0; rxErr = 1'b0;
    rxData = 8'h00; ready = 1'b0; clearErr = 1'b0;
    repeat (3) next();
    check("rst_rxEn", 32'(rxEn), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_count", 32'(fifoCount), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_frameErr", 32'(frameErr), 32'd0);
    check("rst_errCount", 32'(errCount), 32'd0);

    // Cycle 0 is the cycle in which reset releases and enable rises together.
    nReset = 1'b1;
    enable = 1'b1;
    for (int c = 0; c <= 20; c++) begin
      if (c == 13) divisor = 16'd1;
      #1 check($sformatf("strobe_c%0d", c), 32'(rxEn),
               (c <= 16) ? 32'((c % 4) == 0) : 32'((c % 2) == 0));
      next();
    end

    enable = 1'b0;
    divisor = 16'd0;
    for (int c = 0; c < 6; c++) begin
      #1 check("disabled_rxEn", 32'(rxEn), 32'd0);
      next();
    end

    enable = 1'b1; rxDone = 1'b1; rxData = 8'hA5;
    #1 check("single_rxEn", 32'(rxEn), 32'd1);
    next();
    enable = 1'b0; rxDone = 1'b0;
    check("single_valid_n1", 32'(valid), 32'd0);
    next();
    check("single_valid_n2", 32'(valid), 32'd1);
    check("single_data_n2", 32'(data), 32'hA5);
    check("single_count_n2", 32'(fifoCount), 32'd1);
    ready = 1'b1;
    next();
    ready = 1'b0;
    check("single_valid_pop", 32'(valid), 32'd0);
    check("single_count_pop", 32'(fifoCount), 32'd0);
    check("single_data_hold", 32'(data), 32'hA5);

    divisor = 16'd15;
    next();
    enable = 1'b1; rxDone = 1'b1; rxData = 8'h3C;
    repeat (20) next();
    rxDone = 1'b0; enable = 1'b0; divisor = 16'd0;
    next();
    next();
    check("unqual_count", 32'(fifoCount), 32'd1);
    check("unqual_data", 32'(data), 32'h3C);
    ready = 1'b1;
    next();
    ready = 1'b0;
    check("unqual_count_pop", 32'(fifoCount), 32'd0);

    for (int b = 1; b <= 5; b++) send_byte(8'(b));
    next();
    check("ovr_count", 32'(fifoCount), 32'd4);
    check("ovr_flag", 32'(overrun), 32'd1);
    check("ovr_head", 32'(data), 32'h01);
    clearErr = 1'b1;
    next();
    clearErr = 1'b0;
    check("ovr_cleared", 32'(overrun), 32'd0);
    check("ovr_count_kept", 32'(fifoCount), 32'd4);

    enable = 1'b1; rxDone = 1'b1; rxData = 8'h06;
    next();
    enable = 1'b0; rxDone = 1'b0; ready = 1'b1;
    next();
    ready = 1'b0;
    check("fullpp_count", 32'(fifoCount), 32'd4);
    check("fullpp_overrun", 32'(overrun), 32'd0);
    for (int i = 0; i < 4; i++) begin
      ready = 1'b1;
      check($sformatf("drain_%0d", i), 32'(data), 32'(exp_d[i]));
      next();
    end
    ready = 1'b0;
    check("drain_valid", 32'(valid), 32'd0);
    check("drain_count", 32'(fifoCount), 32'd0);

    enable = 1'b1; rxErr = 1'b1;
    repeat (300) next();
    enable = 1'b0; rxErr = 1'b0;
    next();
    check("err_sat", 32'(errCount), 32'd255);
    check("err_frame", 32'(frameErr), 32'd1);
    check("err_nopush", 32'(fifoCount), 32'd0);

    enable = 1'b1; rxErr = 1'b1; clearErr = 1'b1;
    next();
    enable = 1'b0; rxErr = 1'b0; clearErr = 1'b0;
    check("clr_coinc_count", 32'(errCount), 32'd1);
    check("clr_coinc_frame", 32'(frameErr), 32'd1);
    clearErr = 1'b1;
    next();
    clearErr = 1'b0;
    check("clr_count", 32'(errCount), 32'd0);
    check("clr_frame", 32'(frameErr), 32'd0);
    check("clr_overrun", 32'(overrun), 32'd0);

    enable = 1'b1; rxErr = 1'b1;
    next();
    enable = 1'b0; rxErr = 1'b0;
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    check("prerst_count", 32'(fifoCount), 32'd3);
    enable = 1'b1; rxDone = 1'b1; rxData = 8'h44;
    next();
    enable = 1'b0; rxDone = 1'b0;
    nReset = 1'b0;
    #1;
    check("midrst_valid", 32'(valid), 32'd0);
    check("midrst_count", 32'(fifoCount), 32'd0);
    check("midrst_data", 32'(data), 32'd0);
    check("midrst_frame", 32'(frameErr), 32'd0);
    check("midrst_errCount", 32'(errCount), 32'd0);
    check("midrst_rxEn", 32'(rxEn), 32'd0);
    next();
    nReset = 1'b1;
    send_byte(8'h5A);
    check("postrst_valid", 32'(valid), 32'd1);
    check("postrst_data", 32'(data), 32'h5A);
    next();
    check("postrst_count", 32'(fifoCount), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Controller that sequences the oversampling UART receive core. It generates the core's one-cycle `en` oversample strobe from a programmable clock divider and qualifies the core's `done`/`err` outputs with that strobe. Received bytes are captured into a small FIFO with a valid/ready output handshake, and sticky overrun and framing-error status plus a saturating error counter are maintained. It sits between the receive core and the bus-side register block.

## Interface
- `Oversample`, 16, oversample ratio of the attached receive core; documentation and assertion use only.
- `DivWidth`, 16, width of the divider counter and `divisor`.
- `FifoDepth`, 4, number of receive FIFO entries; must be a power of two, ≥2.
- `clk`  in  1  clock.
- `nReset`  in  1  reset, asynchronous, active-low.
- `enable`  in  1  receiver enable; low halts the strobe generator.
- `divisor`  in  DivWidth  clk cycles per oversample strobe, minus 1.
- `rxEn`  out  1  oversample strobe to the core's `en`.
- `rxDone`  in  1  core `done`.
- `rxErr`  in  1  core `err`.
- `rxData`  in  8  core `data`.
- `data`  out  8  FIFO head byte.
- `valid`  out  1  FIFO non-empty.
- `ready`  in  1  consumer accepts the head byte.
- `fifoCount`  out  $clog2(FifoDepth)+1  current occupancy.
- `overrun`  out  1  sticky: a byte was dropped because the FIFO was full.
- `frameErr`  out  1  sticky: the core reported an error.
- `errCount`  out  8  saturating count of core errors.
- `clearErr`  in  1  one-cycle clear of `overrun`, `frameErr` and `errCount`.

## Operation
- **Strobe generator.**
  - Down-counter `divCnt`, reset to 0.
  - With `enable`=1: when `divCnt`==0, assert `rxEn` for that cycle and reload `divisor`; otherwise decrement.
  - With `enable`=0: `rxEn`=0 and `divCnt` loads `divisor`.
  - A change to `divisor` takes effect at the next reload.
  - `divisor`=0 gives `rxEn` high every cycle while enabled.
- **Event qualification.** The core's `done`/`err` are held across non-strobe cycles, so they are only meaningful when `rxEn`=1.
  - Byte event = `rxDone && rxEn`.
  - Error event = `rxErr && rxEn`.
- **Capture.**
  - A byte event sets a one-cycle `capPend` flag.
  - On the cycle `capPend`=1, `rxData` (now updated by the core) is pushed into the FIFO.
- **FIFO.**
  - Circular buffer with read and write pointers of width $clog2(FifoDepth); wrap is natural overflow.
  - Pop when `valid && ready`. `data` = head entry; `data` holds its last value while the FIFO is empty.
  - Push and pop in the same cycle: both occur, count unchanged. This is legal when full: the head is popped and the new byte is written.
  - Push when full with no pop: byte dropped, `overrun` set, FIFO unchanged.
- **Errors.**
  - An error event sets `frameErr` and increments `errCount`, saturating at 255.
  - Error events do not push data.
- **Clear.**
  - `clearErr` zeroes `overrun`, `frameErr` and `errCount`.
  - If a set or increment occurs in the same cycle, the result is the post-clear value of that event: flag = 1, count = 1.
- **Enable deassert.** `enable`=0 does not flush the FIFO or clear status. A pending capture still completes.

## Timing
- **Reset values:** `rxEn`=0, `divCnt`=0, `capPend`=0, `data`=0, `valid`=0, `fifoCount`=0, `overrun`=0, `frameErr`=0, `errCount`=0, both FIFO pointers 0.
- **First strobe:** `enable` rising in cycle 0 gives `rxEn`=1 in cycle 0 (`divCnt`=0 from reset). Subsequent strobes occur every `divisor`+1 cycles.
- **Capture latency:** byte event in cycle N → FIFO write at the end of cycle N+1 → `valid`=1 and updated `fifoCount` in cycle N+2.
- **Handshake:** the pop takes effect at the clock edge. The next head byte appears on `data` the following cycle. `valid` is registered, with no combinational path from `ready`.
- **Status latency:** `overrun`, `frameErr` and `errCount` update one cycle after their triggering event.
- **Reset mid-operation:** asynchronous. All state returns to reset values immediately, and buffered bytes are discarded.

## Test plan
- **Strobe timing:** `divisor`=3, `enable`=1 → `rxEn` pulses on cycles 0, 4, 8, 12. Change `divisor` to 1 mid-count → new 2-cycle period only after the next reload. `enable`=0 → `rxEn` stays 0.
- **Single byte:** core receives 0xA5 → `rxDone`&&`rxEn` at N, `valid`=1 with `data`=0xA5 at N+2. `ready`=1 → `valid`=0 next cycle, `fifoCount`=0.
- **Unqualified done:** `rxDone` held high for 10 cycles with a single `rxEn` → exactly one byte pushed.
- **Overrun:** `ready`=0, receive 5 bytes 0x01..0x05 with `FifoDepth`=4 → `fifoCount`=4, `overrun`=1, drain yields 0x01..0x04. Full + push + pop in the same cycle → no overrun, order preserved.
- **Errors:** 300 error events → `errCount`=255, `frameErr`=1. `clearErr` coincident with an error event → `errCount`=1, `frameErr`=1. `clearErr` alone → all zero.
- **Reset:** assert `nReset` with 3 bytes buffered and a capture pending → all outputs at reset values. After release, the next byte is received correctly.
